// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sample FIFO.
package fifo_pkg;

  localparam int FIFO_DEFAULT_BITS  = 48;
  localparam int FIFO_DEFAULT_DEPTH = 16;

  // One extra MSB on each pointer separates "full" from "empty" when the low bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Sample storage for fifo_interface: synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int num_bits  = 48,
  parameter int addr_bits = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [addr_bits-1:0] wr_addr,
  input  logic [num_bits-1:0]  wr_data,
  input  logic [addr_bits-1:0] rd_addr,
  output logic [num_bits-1:0]  rd_data
);

  logic [num_bits-1:0] mem_reg [2**addr_bits];

  // Contents are deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_addr] <= wr_data;
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/fifo_interface.sv
// First-word-fall-through valid/ready sample FIFO with pointer-based full/empty flags.
// Define FIFO_INTERFACE_COUNT_EN to add the occupancy output "count".
module fifo_interface
  import fifo_pkg::*;
#(
  parameter int num_bits = FIFO_DEFAULT_BITS,
  parameter int depth    = FIFO_DEFAULT_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [num_bits-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [num_bits-1:0]  out_data
`ifdef FIFO_INTERFACE_COUNT_EN
  ,
  output logic [ptr_width(depth)-1:0] count
`endif
);

  localparam int PW = ptr_width(depth);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  logic [PW-1:0] wp_reg;
  logic [PW-1:0] rp_reg;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  assign empty = (wp_reg == rp_reg);
  assign full  = (wp_reg[AW-1:0] == rp_reg[AW-1:0]) && (wp_reg[AW] != rp_reg[AW]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;

  // Pointers wrap naturally at 2*depth because depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_reg <= '0;
      rp_reg <= '0;
    end else begin
      if (push) wp_reg <= wp_reg + PTR_ONE;
      if (pop)  rp_reg <= rp_reg + PTR_ONE;
    end
  end

  fifo_mem #(
    .num_bits  (num_bits),
    .addr_bits (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wp_reg[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rp_reg[AW-1:0]),
    .rd_data (out_data)
  );

`ifdef FIFO_INTERFACE_COUNT_EN
  assign count = wp_reg - rp_reg;
`endif

endmodule

// File: tb/tb_fifo_interface.sv
// Self-checking bench for fifo_interface: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, and randomized streaming.
module tb_fifo_interface;

  localparam int NB    = 48;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_data;
`ifdef FIFO_INTERFACE_COUNT_EN
  logic [4:0]    count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  fifo_interface #(.num_bits(NB), .depth(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FIFO_INTERFACE_COUNT_EN
    ,
    .count     (count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a plain queue of stored words.
  logic [NB-1:0] model_q[$];
  bit            m_push;
  bit            m_pop;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q.delete();
    end else begin
      m_pop  = out_ready && (model_q.size() > 0);
      m_push = in_valid && (model_q.size() < DEPTH);
      if (m_pop)  void'(model_q.pop_front());
      if (m_push) model_q.push_back(in_data);
    end
  end

  // Compare DUT against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    chk("cyc_out_valid", {63'd0, out_valid}, {63'd0, model_q.size() > 0});
    chk("cyc_in_ready",  {63'd0, in_ready},  {63'd0, model_q.size() < DEPTH});
    if (model_q.size() > 0) chk("cyc_out_data", {16'd0, out_data}, {16'd0, model_q[0]});
`ifdef FIFO_INTERFACE_COUNT_EN
    chk("cyc_count", {59'd0, count}, 64'(model_q.size()));
`endif
  end

  task automatic cycle(input logic iv, input logic [NB-1:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
    $display("txn t=%0t in_valid=%0b in_data=%0h out_ready=%0b -> in_ready=%0b out_valid=%0b out_data=%0h",
             $time, iv, d, ordy, in_ready, out_valid, out_data);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1);
  endtask

  task automatic chk_count(input string name, input int exp);
`ifdef FIFO_INTERFACE_COUNT_EN
    chk(name, {59'd0, count}, 64'(exp));
`else
    chk(name, {63'd0, out_valid}, {63'd0, exp != 0});
`endif
  endtask

  logic [NB-1:0] next_word;
  int            pct_v;
  int            pct_r;

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk_count("reset_count", 0);
    reset = 1'b1;

    // Reset mid-run with 5 words buffered.
    for (int i = 0; i < 5; i++) cycle(1'b1, NB'(i + 10), 1'b0);
    chk_count("pre_reset_count", 5);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    chk_count("midrst_count", 0);
    @(posedge clk);
    #1 reset = 1'b1;
    cycle(1'b1, 48'hA5, 1'b0);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_data",  {16'd0, out_data},  64'hA5);
    drain();

    // Fill to full, dropped 17th word, drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, NB'(i), 1'b0);
      chk("fill_in_ready", {63'd0, in_ready}, {63'd0, i < DEPTH});
    end
    cycle(1'b1, 48'hFF, 1'b0);
    chk("full_drop_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_valid", {63'd0, out_valid}, 64'd1);
      chk("drain_data",  {16'd0, out_data},  64'(i));
      cycle(1'b0, '0, 1'b1);
    end
    chk("drained_valid", {63'd0, out_valid}, 64'd0);

    // Simultaneous push/pop while full.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, NB'(100 + i), 1'b0);
    chk_count("sim_full_count", DEPTH);
    cycle(1'b1, NB'(200), 1'b1);
    chk_count("sim_first_edge", DEPTH - 1);
    chk("sim_first_ready", {63'd0, in_ready}, 64'd1);
    chk("sim_first_head",  {16'd0, out_data}, 64'd102);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, NB'(201 + k), 1'b1);
      chk_count("sim_steady_count", DEPTH - 1);
      chk("sim_steady_head", {16'd0, out_data}, 64'(103 + k));
    end
    drain();

    // Pop while empty is ignored; push then appears next cycle.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("empty_pop_valid", {63'd0, out_valid}, 64'd0);
      chk_count("empty_pop_count", 0);
    end
    cycle(1'b1, 48'h123456789ABC, 1'b1);
    chk("empty_push_valid", {63'd0, out_valid}, 64'd1);
    chk("empty_push_data",  {16'd0, out_data},  64'h123456789ABC);
    drain();

    // Randomized streaming with incrementing data, held until accepted.
    next_word = 48'd1000;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin pct_v = 80; pct_r = 30; end
        1: begin pct_v = 30; pct_r = 80; end
        2: begin pct_v = 95; pct_r = 95; end
        default: begin pct_v = 50; pct_r = 50; end
      endcase
      for (int c = 0; c < 250; c++) begin
        logic iv;
        logic orr;
        iv  = ($urandom_range(0, 99) < pct_v);
        orr = ($urandom_range(0, 99) < pct_r);
        in_valid  = iv;
        in_data   = next_word;
        out_ready = orr;
        if (iv && model_q.size() < DEPTH) next_word = next_word + 48'd1;
        @(posedge clk);
        #1;
      end
    end
    drain();
    chk("final_empty", {63'd0, out_valid}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
